instruction_sequencer: RTL and testbench

Instruction front-end that sits directly upstream of the TPU top and drives its 16-bit `instruction` input.
- The host pushes a program into an internal FIFO; a `start` pulse begins issuing.
- Issue rate is one instruction per cycle. After a matmul, NOPs are inserted for a fixed number of cycles so the systolic array can drain.
- When the FIFO empties, the block pulses `done` and returns to idle, driving NOP.

---
 rtl/instruction_sequencer.sv | 129 ++++++++++++
 tb/tb_instruction_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction front-end for the TPU: buffers a host-written program in a FIFO and
// issues it one word per cycle, padding each matmul with NOPs so the array can drain.
module instruction_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [3:0]  MATMUL_OPCODE = 4'h3,
  parameter int unsigned MATMUL_CYCLES = 4,
  parameter logic [15:0] NOP           = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [15:0]              wr_instr,
  output logic                     wr_ready,
  input  logic                     start,
  output logic [15:0]              instruction,
  output logic                     issue_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MATMUL_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   wr_ptr, rd_ptr, count;
  logic [15:0]     mem [DEPTH];
  logic [CW-1:0]   wait_q, wait_d;
  logic [15:0]     instr_d;
  logic            valid_d, done_d;
  logic            full, empty, push, pop;
  logic [15:0]     head;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = wr_valid && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign wr_ready   = !full;
  assign fill_count = count;
  assign busy       = (state != S_IDLE);

  // Storage array; contents are don't-care after reset since pointers are flushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_instr;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // State and registered issue outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_q      <= '0;
      instruction <= NOP;
      issue_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      wait_q      <= wait_d;
      instruction <= instr_d;
      issue_valid <= valid_d;
      done        <= done_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    wait_d  = wait_q;
    instr_d = NOP;
    valid_d = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !empty) state_d = S_RUN;
      end
      S_RUN: begin
        if (!empty) begin
          pop     = 1'b1;
          instr_d = head;
          valid_d = 1'b1;
          if ((head[15:12] == MATMUL_OPCODE) && (MATMUL_CYCLES > 1)) begin
            wait_d  = CW'(MATMUL_CYCLES - 1);
            state_d = S_WAIT;
          end
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Counter hitting zero at this edge hands control back to RUN.
        if (wait_q <= CW'(1)) begin
          wait_d  = '0;
          state_d = S_RUN;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed programs plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_instruction_sequencer;

  localparam int DEPTH = 16;
  localparam int MC    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_instr;
  logic        wr_ready;
  logic        start;
  logic [15:0] instruction;
  logic        issue_valid;
  logic        busy;
  logic        done;
  logic [4:0]  fill_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] q[$];
  bit          m_idle;
  int          m_gap;
  logic [15:0] m_instr;
  bit          m_valid;
  bit          m_done;

  instruction_sequencer #(
    .DEPTH(DEPTH), .MATMUL_OPCODE(4'h3), .MATMUL_CYCLES(MC), .NOP(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_instr(wr_instr),
    .wr_ready(wr_ready), .start(start), .instruction(instruction),
    .issue_valid(issue_valid), .busy(busy), .done(done), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idle  = 1'b1;
    m_gap   = 0;
    m_instr = 16'h0000;
    m_valid = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/instr"}, 32'(instruction), 32'(m_instr));
    check({tag, "/valid"}, 32'(issue_valid), 32'(m_valid));
    check({tag, "/done"},  32'(done),        32'(m_done));
    check({tag, "/busy"},  32'(busy),        32'(!m_idle));
    check({tag, "/fill"},  32'(fill_count),  32'(q.size()));
    check({tag, "/ready"}, 32'(wr_ready),    32'(q.size() != DEPTH));
  endtask

  // One clock: the model consumes the same inputs the DUT sees, then outputs are compared.
  task automatic step(input string tag);
    bit          was_full;
    bit          do_wr;
    bit          do_start;
    logic [15:0] w;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    do_wr    = wr_valid;
    do_start = start;
    w        = wr_instr;
    m_done   = 1'b0;
    m_valid  = 1'b0;
    m_instr  = 16'h0000;
    if (m_idle) begin
      if (do_start && q.size() != 0) m_idle = 1'b0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (q.size() != 0) begin
      m_instr = q.pop_front();
      m_valid = 1'b1;
      if (m_instr[15:12] == 4'h3) m_gap = MC - 1;
    end else begin
      m_done = 1'b1;
      m_idle = 1'b1;
    end
    if (do_wr && !was_full) q.push_back(w);
    #1;
    compare_all(tag);
  endtask

  task automatic write_word(input logic [15:0] w, input string tag);
    wr_valid = 1'b1;
    wr_instr = w;
    step(tag);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    step(tag);
    start = 1'b0;
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_instr = 16'h0000;
    start    = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Plain three-word program
    write_word(16'h1001, "p1_wr");
    write_word(16'h2002, "p1_wr");
    write_word(16'h4004, "p1_wr");
    pulse_start("p1_start");
    idle_steps(6, "p1_run");

    // Matmul followed by a plain word
    write_word(16'h3010, "p2_wr");
    write_word(16'h1001, "p2_wr");
    pulse_start("p2_start");
    idle_steps(9, "p2_run");

    // Overflow: 17th write is dropped
    for (int i = 0; i < 17; i++) write_word(16'h1100 + 16'(i), "p3_wr");
    pulse_start("p3_start");
    idle_steps(20, "p3_run");

    // Start with empty FIFO is ignored
    pulse_start("p5_empty_start");
    idle_steps(3, "p5_empty");

    // Asynchronous reset in the middle of a matmul wait
    write_word(16'h3abc, "p6_wr");
    write_word(16'h1001, "p6_wr");
    pulse_start("p6_start");
    idle_steps(2, "p6_run");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    idle_steps(4, "p6_after");

    // Random traffic: writes, matmuls and start pulses in all states
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      wr_valid = ($urandom_range(0, 99) < 45);
      op       = ($urandom_range(0, 9) < 3) ? 4'h3 : 4'($urandom_range(0, 15));
      wr_instr = {op, 12'($urandom)};
      start    = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    idle_steps(60, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
